// File: rtl/slip_cnt_pkg.sv
// Shared Slipstream counter encodings: count direction and terminal-count mode.
package slip_cnt_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_WRAP   = 1'b0,
    MODE_RELOAD = 1'b1
  } mode_e;

endpackage : slip_cnt_pkg

// File: rtl/m_CLKEDGE.sv
// Rising-edge detector for a logical clock sampled in the MasterClock domain.
module m_CLKEDGE (
  input  logic MasterClock,
  input  logic RESET,
  input  logic CLK,
  output logic TICK
);

  logic clk_q;
  logic clk_d;

  assign clk_d = CLK;

  // History resets high so a CLK already high at reset release yields no tick.
  always_ff @(posedge MasterClock) begin
    if (RESET) begin
      clk_q <= 1'b1;
    end else begin
      clk_q <= clk_d;
    end
  end

  assign TICK = CLK & ~clk_q;

endmodule : m_CLKEDGE

// File: rtl/syncnt_wide.sv
// Wide synchronous up/down counter with load, clear, auto-reload and cascade carry,
// advanced by rising edges of CLK sampled in the MasterClock domain.
module syncnt_wide
  import slip_cnt_pkg::*;
#(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             MasterClock,
  input  logic             RESET,
  input  logic             CLK,
  input  logic             CLR,
  input  logic             LDL,
  input  logic             CI,
  input  logic             UP,
  input  logic             AUTO,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QB,
  output logic             CO,
  output logic             TC
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  logic             tick_s;
  logic             term_s;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             tc_q;
  logic             tc_d;

  m_CLKEDGE u_clkedge (
    .MasterClock (MasterClock),
    .RESET       (RESET),
    .CLK         (CLK),
    .TICK        (tick_s)
  );

  assign term_s = (UP == DIR_UP) ? (&q_q) : (q_q == ZERO);

  // Next-state: clear beats load beats count; only the count path raises TC.
  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
    if (tick_s) begin
      if (CLR) begin
        q_d = RESET_VAL;
      end else if (!LDL) begin
        q_d = D;
      end else if (CI) begin
        tc_d = term_s;
        if ((AUTO == MODE_RELOAD) && term_s) begin
          q_d = D;
        end else if (UP == DIR_UP) begin
          q_d = q_q + ONE;
        end else begin
          q_d = q_q - ONE;
        end
      end else begin
        q_d = q_q;
      end
    end else begin
      q_d = q_q;
    end
  end

  // Count and terminal-count registers.
  always_ff @(posedge MasterClock) begin
    if (RESET) begin
      q_q  <= RESET_VAL;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      tc_q <= tc_d;
    end
  end

  assign Q  = q_q;
  assign QB = ~q_q;
  assign TC = tc_q;
  // Combinational on purpose: lets a higher stage see the enable within the same tick.
  assign CO = CI & term_s;

endmodule : syncnt_wide

// File: tb/tb_syncnt_wide.sv
// Directed self-checking bench for syncnt_wide: single 8-bit counter plus a 4+4 cascade.
module tb_syncnt_wide;

  logic       mc;
  logic       rst;
  logic       clk8, clr, ldl, ci, up, auto_m;
  logic [7:0] d8, q8, qb8;
  logic       co8, tc8;

  logic       cclk;
  logic [3:0] ql, qbl, qh, qbh;
  logic       col, coh, tcl, tch;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  syncnt_wide #(.WIDTH(8), .RESET_VAL(8'h12)) dut (
    .MasterClock(mc), .RESET(rst), .CLK(clk8), .CLR(clr), .LDL(ldl), .CI(ci),
    .UP(up), .AUTO(auto_m), .D(d8), .Q(q8), .QB(qb8), .CO(co8), .TC(tc8)
  );

  syncnt_wide #(.WIDTH(4)) u_lo (
    .MasterClock(mc), .RESET(rst), .CLK(cclk), .CLR(1'b0), .LDL(1'b1), .CI(1'b1),
    .UP(1'b1), .AUTO(1'b0), .D(4'h0), .Q(ql), .QB(qbl), .CO(col), .TC(tcl)
  );

  syncnt_wide #(.WIDTH(4)) u_hi (
    .MasterClock(mc), .RESET(rst), .CLK(cclk), .CLR(1'b0), .LDL(1'b1), .CI(col),
    .UP(1'b1), .AUTO(1'b0), .D(4'h0), .Q(qh), .QB(qbh), .CO(coh), .TC(tch)
  );

  initial mc = 1'b0;
  always #5 mc = ~mc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge mc);
    #1;
  endtask

  // One CLK rising edge; returns 1ns after the MasterClock edge that consumed it.
  task automatic tick8();
    cyc(1); clk8 = 1'b1;
    cyc(1); clk8 = 1'b0;
  endtask

  task automatic tickc();
    cyc(1); cclk = 1'b1;
    cyc(1); cclk = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clk8 = 1'b0; cclk = 1'b0; clr = 1'b0; ldl = 1'b1; ci = 1'b0;
    up = 1'b1; auto_m = 1'b0; d8 = 8'h00;
    cyc(3);
    chk("reset_q", q8, 32'h12);
    chk("reset_qb", qb8, 32'hED);
    chk("reset_tc", tc8, 32'h0);
    rst = 1'b0;
    cyc(1);

    // Wrap upward through all-ones.
    ldl = 1'b0; d8 = 8'hFE; tick8();
    chk("load_fe", q8, 32'hFE);
    chk("load_no_tc", tc8, 32'h0);
    ldl = 1'b1; ci = 1'b1; up = 1'b1; auto_m = 1'b0;
    chk("co_fe", co8, 32'h0);
    tick8();
    chk("up_ff", q8, 32'hFF);
    chk("tc_ff", tc8, 32'h0);
    chk("co_ff", co8, 32'h1);
    tick8();
    chk("wrap_00", q8, 32'h00);
    chk("wrap_tc", tc8, 32'h1);
    chk("co_00_up", co8, 32'h0);
    cyc(1);
    chk("wrap_tc_one_cycle", tc8, 32'h0);

    // Down with auto-reload.
    ldl = 1'b0; d8 = 8'h01; tick8();
    chk("load_01", q8, 32'h01);
    ldl = 1'b1; d8 = 8'h05; up = 1'b0; auto_m = 1'b1;
    tick8();
    chk("down_00", q8, 32'h00);
    chk("down_tc0", tc8, 32'h0);
    chk("co_00_down", co8, 32'h1);
    tick8();
    chk("reload_05", q8, 32'h05);
    chk("reload_tc", tc8, 32'h1);
    chk("qb_05", qb8, 32'hFA);
    cyc(1);
    chk("reload_tc_one_cycle", tc8, 32'h0);

    // Clear beats load beats count.
    clr = 1'b1; ldl = 1'b0; ci = 1'b1; d8 = 8'hAA; tick8();
    chk("clr_prio", q8, 32'h12);
    chk("clr_no_tc", tc8, 32'h0);
    clr = 1'b0; tick8();
    chk("load_aa", q8, 32'hAA);

    // Hold with CI=0; D/UP wiggles between ticks have no effect.
    ldl = 1'b1; ci = 1'b0; up = 1'b1; auto_m = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d8 = 8'h30 + 8'(i);
      tick8();
    end
    chk("hold_5", q8, 32'hAA);
    up = 1'b0; ldl = 1'b0; cyc(2); up = 1'b1; ldl = 1'b1;
    chk("between_ticks", q8, 32'hAA);

    // CLK held high counts once.
    ci = 1'b1;
    cyc(1); clk8 = 1'b1;
    cyc(10);
    chk("held_high_once", q8, 32'hAB);
    clk8 = 1'b0; cyc(1);
    chk("held_no_extra", q8, 32'hAB);

    // Reset wins over a simultaneous tick; CLK high at release gives no count.
    ldl = 1'b0; d8 = 8'h3C; tick8();
    chk("load_3c", q8, 32'h3C);
    ldl = 1'b1; ci = 1'b1;
    clk8 = 1'b1; rst = 1'b1;
    cyc(1);
    chk("rst_tick_q", q8, 32'h12);
    chk("rst_tick_tc", tc8, 32'h0);
    rst = 1'b0;
    cyc(3);
    chk("rst_release_no_count", q8, 32'h12);
    clk8 = 1'b0;
    tick8();
    chk("post_reset_count", q8, 32'h13);

    // 4+4 cascade over 16 ticks.
    for (int i = 0; i < 15; i++) tickc();
    chk("cascade_0f", {qh, ql}, 32'h0F);
    chk("cascade_co_lo", col, 32'h1);
    tickc();
    chk("cascade_10", {qh, ql}, 32'h10);
    chk("cascade_tc_lo", tcl, 32'h1);
    chk("cascade_tc_hi", tch, 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_syncnt_wide
